qosc_regbank: RTL

Parametrised, double-buffered configuration register bank for the quadrature oscillator core. The host writes shadow registers over a byte-wide address/data port; shadow contents are copied atomically into the active registers that drive the oscillator only when a commit is requested and the core signals a safe sample boundary (`sync_ok`), or a timeout expires. It adds read-back, status, sticky error flags and an auto-commit mode to the oscillator's configuration path.

---
 rtl/qosc_regbank_pkg.sv | 23 ++
 rtl/qosc_commit_fsm.sv | 67 ++++++
 rtl/qosc_regbank.sv | 133 +++++++++++++
 3 files changed

// File: rtl/qosc_regbank_pkg.sv
// Shared types and constants for the quadrature oscillator configuration register bank.
package qosc_regbank_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    APPLY   = 2'd2
  } state_e;

  localparam int unsigned ADDR_STATUS   = 0;
  localparam int unsigned ADDR_CTRL     = 1;
  localparam int unsigned ADDR_CFG_BASE = 2;

  localparam int unsigned ST_BIT_PENDING = 0;
  localparam int unsigned ST_BIT_WR_ERR  = 1;
  localparam int unsigned ST_BIT_TIMEOUT = 2;
  localparam int unsigned ST_BIT_AUTO    = 3;

  localparam int unsigned CTRL_BIT_COMMIT   = 0;
  localparam int unsigned CTRL_BIT_AUTO     = 1;
  localparam int unsigned CTRL_BIT_DEFAULTS = 2;

endpackage

// File: rtl/qosc_commit_fsm.sv
// Commit sequencer: waits in PENDING for a safe sample boundary or a timeout,
// then spends one APPLY cycle while the active registers take the shadow copy.
module qosc_commit_fsm
  import qosc_regbank_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic   clk,
  input  logic   reset_n,
  input  logic   commit_req,
  input  logic   sync_ok,
  output logic   apply,
  output logic   busy,
  output logic   timeout_hit,
  output logic   load,
  output state_e state
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  // Count value seen during the last allowed PENDING cycle.
  localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT_CYC == 0) ? '0 : CNT_W'(TIMEOUT_CYC - 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             w_to;

  assign w_to = (TIMEOUT_CYC != 0) && (r_cnt == TO_LAST);

  always_comb begin
    w_state_nxt = r_state;
    load        = 1'b0;
    timeout_hit = 1'b0;
    case (r_state)
      IDLE:    if (commit_req) w_state_nxt = PENDING;
      PENDING: begin
        // sync_ok has priority so a coincident timeout is not flagged
        if (sync_ok) begin
          w_state_nxt = APPLY;
          load        = 1'b1;
        end else if (w_to) begin
          w_state_nxt = APPLY;
          load        = 1'b1;
          timeout_hit = 1'b1;
        end
      end
      APPLY:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && w_state_nxt == PENDING) r_cnt <= '0;
      else if (r_state == PENDING && r_cnt != '1)    r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign apply = (r_state == APPLY);
  assign busy  = (r_state != IDLE);
  assign state = r_state;

endmodule

// File: rtl/qosc_regbank.sv
// Double-buffered oscillator config bank: host writes shadow registers, which
// are copied atomically to cfg_active by the commit sequencer.
module qosc_regbank
  import qosc_regbank_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ADDR_W      = 3,
  parameter int unsigned NUM_CFG     = 5,
  parameter logic [NUM_CFG*DATA_W-1:0] RESET_VALS = 40'h10_1b_7d_00_20,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      wr_en,
  input  logic                      rd_en,
  input  logic [ADDR_W-1:0]         address,
  input  logic [DATA_W-1:0]         data_in,
  output logic [DATA_W-1:0]         data_out,
  output logic                      rd_valid,
  input  logic                      sync_ok,
  output logic [NUM_CFG*DATA_W-1:0] cfg_active,
  output logic                      cfg_update,
  output logic                      busy
);

  localparam int unsigned IDX_W = (NUM_CFG < 2) ? 1 : $clog2(NUM_CFG);

  logic [NUM_CFG*DATA_W-1:0] r_shadow;
  logic [NUM_CFG*DATA_W-1:0] r_active;
  logic [DATA_W-1:0]         r_data_out;
  logic                      r_rd_valid;
  logic                      r_auto;
  logic                      r_wr_err;
  logic                      r_timeout;

  logic              w_is_status, w_is_ctrl, w_is_cfg;
  logic [IDX_W-1:0]  w_cfg_idx;
  logic              w_busy, w_idle, w_pending;
  logic              w_apply, w_load, w_timeout_hit;
  state_e            w_state;
  logic              w_shadow_we, w_defaults, w_err_set, w_commit_req, w_status_rd;
  logic [DATA_W-1:0] w_rd_data;

  assign w_is_status = (address == ADDR_W'(ADDR_STATUS));
  assign w_is_ctrl   = (address == ADDR_W'(ADDR_CTRL));
  // Extra bit keeps the upper bound representable when the map fills the space.
  assign w_is_cfg    = (address >= ADDR_W'(ADDR_CFG_BASE)) &&
                       ({1'b0, address} < (ADDR_W+1)'(ADDR_CFG_BASE + NUM_CFG));
  assign w_cfg_idx   = IDX_W'(address - ADDR_W'(ADDR_CFG_BASE));

  assign w_idle       = ~w_busy;
  assign w_pending    = (w_state != IDLE);
  assign w_shadow_we  = wr_en && w_is_cfg && w_idle;
  assign w_defaults   = wr_en && w_is_ctrl && data_in[CTRL_BIT_DEFAULTS] && w_idle;
  assign w_err_set    = wr_en && w_busy &&
                        (w_is_cfg || (w_is_ctrl && (data_in[CTRL_BIT_COMMIT] || data_in[CTRL_BIT_DEFAULTS])));
  assign w_commit_req = wr_en && w_idle &&
                        ((w_is_ctrl && data_in[CTRL_BIT_COMMIT]) || (r_auto && w_is_cfg));
  assign w_status_rd  = rd_en && w_is_status;

  qosc_commit_fsm #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_fsm (
    .clk         (clk),
    .reset_n     (reset_n),
    .commit_req  (w_commit_req),
    .sync_ok     (sync_ok),
    .apply       (w_apply),
    .busy        (w_busy),
    .timeout_hit (w_timeout_hit),
    .load        (w_load),
    .state       (w_state)
  );

  always_comb begin
    w_rd_data = '0;
    if (w_is_status) begin
      w_rd_data[ST_BIT_PENDING] = w_pending;
      w_rd_data[ST_BIT_WR_ERR]  = r_wr_err;
      w_rd_data[ST_BIT_TIMEOUT] = r_timeout;
      w_rd_data[ST_BIT_AUTO]    = r_auto;
    end else if (w_is_ctrl) begin
      w_rd_data[CTRL_BIT_AUTO] = r_auto;
    end else if (w_is_cfg) begin
      for (int i = 0; i < NUM_CFG; i++)
        if (w_cfg_idx == IDX_W'(i)) w_rd_data = r_shadow[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shadow <= RESET_VALS;
      r_active <= RESET_VALS;
    end else begin
      if (w_defaults) r_shadow <= RESET_VALS;
      else if (w_shadow_we) begin
        for (int i = 0; i < NUM_CFG; i++)
          if (w_cfg_idx == IDX_W'(i)) r_shadow[i*DATA_W +: DATA_W] <= data_in;
      end
      if (w_load) r_active <= r_shadow;
    end
  end

  // Sticky flags: a STATUS read clears them, a coincident set wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_auto    <= 1'b0;
      r_wr_err  <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      if (wr_en && w_is_ctrl) r_auto <= data_in[CTRL_BIT_AUTO];
      if (w_err_set)          r_wr_err <= 1'b1;
      else if (w_status_rd)   r_wr_err <= 1'b0;
      if (w_timeout_hit)      r_timeout <= 1'b1;
      else if (w_status_rd)   r_timeout <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data_out <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= rd_en;
      if (rd_en) r_data_out <= w_rd_data;
    end
  end

  assign data_out   = r_data_out;
  assign rd_valid   = r_rd_valid;
  assign cfg_active = r_active;
  assign cfg_update = w_apply;
  assign busy       = w_busy;

endmodule
